fetch_sequencer: RTL and testbench

//  Instruction-fetch controller for the single-issue MIPS core. Holds the PC and

---
 rtl/fetch_sequencer.sv | 106 ++++++++++
 tb/tb_fetch_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fetches over a req/ack memory port,
// issues words to decode over valid/ready, and applies branch/jump redirects.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        br_taken,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_offset,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    output logic        fetch_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        ERROR = 2'd3
    } state_e;

    // Counter only has to reach TIMEOUT-1; the TIMEOUT-th silent cycle trips the error.
    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q;
    logic [31:0]   pc_q;
    logic [CW-1:0] wait_cnt_q;
    logic [31:0]   instr_q;
    logic [31:0]   instr_pc_q;
    logic          fetch_err_q;

    logic [31:0]   br_target_d;
    logic [31:0]   redir_target_d;
    logic          redir_d;
    logic          redir_misaligned_d;

    // Branch wins over a simultaneous jump; redirects never apply once in ERROR.
    always_comb begin
        br_target_d        = br_pc + 32'd4 + br_offset;
        redir_target_d     = br_taken ? br_target_d : jmp_target;
        redir_d            = (br_taken | jmp_valid) && (state_q != ERROR);
        redir_misaligned_d = |redir_target_d[1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            wait_cnt_q  <= '0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            fetch_err_q <= 1'b0;
        end else if (redir_d) begin
            // Redirect outranks ack and timeout; a bad target leaves pc untouched.
            if (redir_misaligned_d) begin
                fetch_err_q <= 1'b1;
                state_q     <= ERROR;
            end else begin
                pc_q       <= redir_target_d;
                wait_cnt_q <= '0;
                state_q    <= FETCH;
            end
        end else begin
            case (state_q)
                IDLE: state_q <= FETCH;
                FETCH: begin
                    if (imem_ack) begin
                        instr_q    <= imem_rdata;
                        instr_pc_q <= pc_q;
                        pc_q       <= pc_q + 32'd4;
                        wait_cnt_q <= '0;
                        state_q    <= ISSUE;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        fetch_err_q <= 1'b1;
                        state_q     <= ERROR;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CW'(1);
                    end
                end
                ISSUE: if (instr_ready) state_q <= FETCH;
                default: state_q <= ERROR;
            endcase
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == ISSUE);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_err   = fetch_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, stall, redirects,
// timeout, misaligned target, reset recovery and PC wrap.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        br_taken;
    logic [31:0] br_pc;
    logic [31:0] br_offset;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        fetch_err;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(32'h0), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .br_taken(br_taken), .br_pc(br_pc), .br_offset(br_offset),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .fetch_err(fetch_err), .dbg_state(dbg_state)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        imem_ack = 0; imem_rdata = 0; instr_ready = 0;
        br_taken = 0; br_pc = 0; br_offset = 0; jmp_valid = 0; jmp_target = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=00000000", imem_addr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=00000000", instr); end
        n_checks++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc got=%h exp=00000000", instr_pc); end
        n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", fetch_err); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        tick();  // IDLE -> FETCH
        instr_ready = 1;
        for (int i = 0; i < 3; i++) begin
            a = 32'(i * 4);
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin n_fail++; $display("FAIL seq_fetch%0d req=%b addr=%h exp_addr=%h", i, imem_req, imem_addr, a); end
            n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq_novalid%0d got=%b exp=0", i, instr_valid); end
            imem_ack = 1; imem_rdata = 32'hA000_0000 | a;
            tick();
            imem_ack = 0;
            n_checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_issue%0d valid=%b req=%b exp valid=1 req=0", i, instr_valid, imem_req); end
            n_checks++; if (instr_pc !== a || instr !== (32'hA000_0000 | a)) begin n_fail++; $display("FAIL seq_data%0d pc=%h instr=%h exp pc=%h", i, instr_pc, instr, a); end
            tick();
        end
        n_checks++; if (imem_addr !== 32'hC || imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_next addr=%h req=%b exp addr=0000000c req=1", imem_addr, imem_req); end
    endtask

    task automatic test_stall();
        instr_ready = 0;
        imem_ack = 1; imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 0; imem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_hs%0d valid=%b req=%b exp valid=1 req=0", i, instr_valid, imem_req); end
            n_checks++; if (instr !== 32'h1234_5678 || instr_pc !== 32'hC) begin n_fail++; $display("FAIL stall_hold%0d instr=%h pc=%h exp 12345678/0000000c", i, instr, instr_pc); end
            n_checks++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL stall_pc%0d got=%h exp=00000010", i, imem_addr); end
        end
        instr_ready = 1;
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release req=%b addr=%h valid=%b exp 1/00000010/0", imem_req, imem_addr, instr_valid); end
    endtask

    task automatic test_branch_ack();
        br_taken = 1; br_pc = 32'h100; br_offset = 32'hFFFF_FFF0;
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        instr_ready = 0;
        tick();
        clear_inputs();
        n_checks++; if (imem_addr !== 32'hF4 || imem_req !== 1'b1) begin n_fail++; $display("FAIL br_addr got=%h req=%b exp=000000f4 req=1", imem_addr, imem_req); end
        n_checks++; if (instr_valid !== 1'b0 || instr !== 32'h1234_5678 || instr_pc !== 32'hC) begin n_fail++; $display("FAIL br_drop valid=%b instr=%h pc=%h exp 0/12345678/0000000c", instr_valid, instr, instr_pc); end
        imem_ack = 1; imem_rdata = 32'hB000_00F4;
        tick();
        imem_ack = 0;
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'hB000_00F4 || instr_pc !== 32'hF4) begin n_fail++; $display("FAIL br_issue valid=%b instr=%h pc=%h exp 1/b00000f4/000000f4", instr_valid, instr, instr_pc); end
    endtask

    task automatic test_branch_jump();
        br_taken = 1; br_pc = 32'h20; br_offset = 32'h8;
        jmp_valid = 1; jmp_target = 32'h400;
        tick();
        clear_inputs();
        n_checks++; if (imem_addr !== 32'h2C || imem_req !== 1'b1) begin n_fail++; $display("FAIL brj_addr got=%h req=%b exp=0000002c req=1", imem_addr, imem_req); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL brj_squash got=%b exp=0", instr_valid); end
    endtask

    task automatic test_timeout();
        for (int i = 1; i <= 15; i++) begin
            tick();
            n_checks++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL to_early%0d err=%b req=%b exp err=0 req=1", i, fetch_err, imem_req); end
        end
        tick();
        n_checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL to_trip err=%b req=%b valid=%b exp 1/0/0", fetch_err, imem_req, instr_valid); end
        n_checks++; if (dbg_state !== 2'd3) begin n_fail++; $display("FAIL to_state got=%0d exp=3", dbg_state); end
        jmp_valid = 1; jmp_target = 32'h800;
        tick();
        jmp_valid = 0;
        tick();
        n_checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h2C) begin n_fail++; $display("FAIL to_ignore err=%b req=%b addr=%h exp 1/0/0000002c", fetch_err, imem_req, imem_addr); end
    endtask

    task automatic test_misaligned();
        test_reset();
        jmp_valid = 1; jmp_target = 32'h202;
        tick();
        clear_inputs();
        n_checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL mis_err err=%b req=%b exp 1/0", fetch_err, imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL mis_pc got=%h exp=00000000", imem_addr); end
        test_reset();
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL mis_restart req=%b addr=%h err=%b exp 1/00000000/0", imem_req, imem_addr, fetch_err); end
    endtask

    task automatic test_wrap();
        jmp_valid = 1; jmp_target = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_jump got=%h exp=fffffffc", imem_addr); end
        imem_ack = 1; imem_rdata = 32'h0BAD_F00D;
        tick();
        imem_ack = 0;
        n_checks++; if (instr_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL wrap_pc instr_pc=%h addr=%h err=%b exp fffffffc/00000000/0", instr_pc, imem_addr, fetch_err); end
        // Redirect together with ready: handshake completes, target still taken.
        instr_ready = 1; jmp_valid = 1; jmp_target = 32'h40;
        tick();
        clear_inputs();
        n_checks++; if (imem_addr !== 32'h40 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_ready addr=%h req=%b valid=%b exp 00000040/1/0", imem_addr, imem_req, instr_valid); end
    endtask

    initial begin
        rst_n = 1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_branch_ack();
        test_branch_jump();
        test_timeout();
        test_misaligned();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
